// File: rtl/cache_line_fill_ctrl.sv
// cache_line_fill_ctrl: fetches a 256-bit cache line as eight 32-bit beats,
// writes line + tag in one cycle, and arbitrates the single RAM write port
// between line fills and full-line store-hit writes.
module cache_line_fill_ctrl #(
    parameter int NL  = 256,
    parameter int LSS = 8
) (
    input  logic              nGCLK,
    input  logic              nRESET,
    input  logic              miss_req,
    input  logic [31:0]       miss_addr,
    output logic              miss_ack,
    output logic              busy,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_rdy,
    input  logic [31:0]       mem_data,
    input  logic              st_req,
    input  logic [LSS-1:0]    st_sel,
    input  logic [255:0]      st_line,
    output logic              st_gnt,
    output logic [LSS-1:0]    write_sel,
    output logic [255:0]      write_port,
    output logic              wr_ena,
    output logic              tag_we,
    output logic [26-LSS:0]   tag_val
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] LWRITE = 2'd2;

    logic [1:0]       state;
    logic [31:5]      addr_q;
    logic [2:0]       cnt;
    logic [7:0][31:0] line_buf;
    logic [LSS-1:0]   fill_sel;
    logic             conflict;
    logic [31:0]      unused_cfg;

    // Offset bits and the line-count parameter are not needed by the logic.
    assign unused_cfg = 32'(NL) ^ {27'b0, miss_addr[4:0]};

    assign fill_sel = addr_q[LSS+4:5];
    assign mem_addr = {addr_q, 5'b0};
    assign tag_val  = addr_q[31:LSS+5];
    assign busy     = (state != IDLE);

    // A store to the line being filled would be overwritten by stale fill data
    // ordering, so it is held off until the fill write has landed.
    assign conflict = (state == FILL) && (st_sel == fill_sel);
    assign st_gnt   = st_req && (state != LWRITE) && !conflict;

    // Fill sequencer: accept miss, collect eight beats, hand off to LWRITE.
    always_ff @(posedge nGCLK) begin
        if (!nRESET) begin
            state    <= IDLE;
            addr_q   <= '0;
            cnt      <= '0;
            line_buf <= '0;
            mem_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_req && !miss_ack) begin
                        addr_q  <= miss_addr[31:5];
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (mem_rdy) begin
                        line_buf[cnt] <= mem_data;
                        cnt           <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            mem_req <= 1'b0;
                            state   <= LWRITE;
                        end
                    end
                end
                LWRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write port: fill write in LWRITE has priority, else a granted store.
    always_ff @(posedge nGCLK) begin
        if (!nRESET) begin
            wr_ena     <= 1'b0;
            write_sel  <= '0;
            write_port <= '0;
            tag_we     <= 1'b0;
            miss_ack   <= 1'b0;
        end else if (state == LWRITE) begin
            wr_ena     <= 1'b1;
            write_sel  <= fill_sel;
            write_port <= line_buf;
            tag_we     <= 1'b1;
            miss_ack   <= 1'b1;
        end else begin
            tag_we   <= 1'b0;
            miss_ack <= 1'b0;
            if (st_gnt) begin
                wr_ena     <= 1'b1;
                write_sel  <= st_sel;
                write_port <= st_line;
            end else begin
                wr_ena <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Directed self-checking bench for cache_line_fill_ctrl.
module tb_cache_line_fill_ctrl;

    logic         nGCLK;
    logic         nRESET;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         miss_ack;
    logic         busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_rdy;
    logic [31:0]  mem_data;
    logic         st_req;
    logic [7:0]   st_sel;
    logic [255:0] st_line;
    logic         st_gnt;
    logic [7:0]   write_sel;
    logic [255:0] write_port;
    logic         wr_ena;
    logic         tag_we;
    logic [18:0]  tag_val;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int wr_cnt = 0;

    logic [31:0]  mem_base = 32'h100;
    bit           mem_alt = 1'b0;
    logic [255:0] st_pat = {8{32'hCAFE_F00D}};

    cache_line_fill_ctrl #(.NL(256), .LSS(8)) dut (
        .nGCLK(nGCLK), .nRESET(nRESET),
        .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack),
        .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdy(mem_rdy), .mem_data(mem_data),
        .st_req(st_req), .st_sel(st_sel), .st_line(st_line), .st_gnt(st_gnt),
        .write_sel(write_sel), .write_port(write_port), .wr_ena(wr_ena),
        .tag_we(tag_we), .tag_val(tag_val)
    );

    // Clock
    initial begin
        nGCLK = 1'b0;
        forever #5 nGCLK = ~nGCLK;
    end

    // Memory bus model: beat i carries mem_base+i; optional alternate-cycle stall
    initial begin
        int  beat;
        int  n;
        bit  took;
        beat = 0;
        n = 0;
        mem_rdy = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge nGCLK);
            took = mem_req && mem_rdy;
            @(posedge nGCLK);
            #1;
            if (took) beat++;
            if (!mem_req) begin
                beat = 0;
                n = 0;
            end else begin
                n++;
            end
            mem_data = mem_base + 32'(beat);
            mem_rdy  = mem_alt ? (n % 2 == 0) : 1'b1;
        end
    end

    // Event counters for acks and RAM writes
    initial begin
        forever begin
            @(posedge nGCLK);
            #1;
            if (miss_ack) ack_cnt++;
            if (wr_ena) wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge nGCLK);
        #2;
    endtask

    // One complete fill; miss_req is held through the ack cycle, then dropped.
    task automatic do_fill(input logic [31:0] addr, input logic [31:0] base, input bit alt,
                           input int exp_ack, input bit st_en, input logic [7:0] st_idx,
                           input logic [7:0] exp_sel, input logic [18:0] exp_tag);
        logic [255:0] exp_line;
        int  ack_at;
        int  last_req;
        int  acks0;
        bit  gnt_exp;
        bit  st_pending;
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = base + 32'(i);
        mem_alt = alt;
        mem_base = base;
        miss_addr = addr;
        miss_req = 1'b1;
        ack_at = -1;
        last_req = -1;
        st_pending = 1'b0;
        acks0 = ack_cnt;
        for (int e = 0; e < 40; e++) begin
            if (st_en && e == 3) begin
                st_req = 1'b1;
                st_sel = st_idx;
                st_line = st_pat;
                st_pending = 1'b1;
            end
            gnt_exp = 1'b0;
            if (st_req) begin
                gnt_exp = (st_idx != exp_sel) || (ack_at >= 0);
                #1;
                check("st_gnt", st_gnt, gnt_exp);
            end
            tick();
            if (mem_req) last_req = e;
            if (e == 0) begin
                check("accept_mem_req", mem_req, 1'b1);
                check("accept_mem_addr", mem_addr, {addr[31:5], 5'b0});
                check("accept_busy", busy, 1'b1);
            end
            if (gnt_exp) begin
                check("store_wr_ena", wr_ena, 1'b1);
                check("store_sel", write_sel, st_idx);
                check("store_data", write_port, st_pat);
                check("store_tag_we", tag_we, 1'b0);
                st_req = 1'b0;
                st_pending = 1'b0;
            end
            if (miss_ack) begin
                ack_at = e;
                check("fill_wr_ena", wr_ena, 1'b1);
                check("fill_tag_we", tag_we, 1'b1);
                check("fill_sel", write_sel, exp_sel);
                check("fill_line", write_port, exp_line);
                check("fill_tag_val", tag_val, exp_tag);
            end else if (ack_at >= 0 && e == ack_at + 1) begin
                check("no_reaccept_busy", busy, 1'b0);
                check("ack_one_cycle", miss_ack, 1'b0);
                miss_req = 1'b0;
            end
            if (ack_at >= 0 && e > ack_at + 1 && !st_pending) break;
        end
        check("ack_edge", ack_at, exp_ack);
        check("mem_req_last", last_req, exp_ack - 2);
        check("ack_count", ack_cnt - acks0, 1);
        check("idle_after", busy, 1'b0);
        st_req = 1'b0;
        miss_req = 1'b0;
    endtask

    // Directed test sequence
    initial begin
        int acks0;
        int wrs0;
        nRESET = 1'b0;
        miss_req = 1'b0;
        miss_addr = '0;
        st_req = 1'b0;
        st_sel = '0;
        st_line = '0;
        repeat (3) tick();

        check("rst_wr_ena", wr_ena, 1'b0);
        check("rst_miss_ack", miss_ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_write_sel", write_sel, 8'h0);
        check("rst_write_port", write_port, 256'h0);
        check("rst_tag", {tag_we, tag_val}, 20'h0);
        check("rst_st_gnt", st_gnt, 1'b0);
        nRESET = 1'b1;
        tick();

        // T1: zero-wait fill
        do_fill(32'h0000_1A40, 32'h100, 1'b0, 9, 1'b0, 8'h00, 8'hD2, 19'h0);
        // T2: alternate-cycle stalls
        do_fill(32'h0000_1A40, 32'h100, 1'b1, 17, 1'b0, 8'h00, 8'hD2, 19'h0);
        // T3: non-conflicting store during fill
        do_fill(32'h0000_1A40, 32'h100, 1'b0, 9, 1'b1, 8'h05, 8'hD2, 19'h0);
        // T4: store to the fill index waits until the fill write is done
        do_fill(32'h0000_1A40, 32'h100, 1'b0, 9, 1'b1, 8'hD2, 8'hD2, 19'h0);

        // Store in IDLE: one-cycle write, then write_sel holds
        st_req = 1'b1;
        st_sel = 8'h33;
        st_line = st_pat;
        #1;
        check("idle_st_gnt", st_gnt, 1'b1);
        tick();
        check("idle_st_wr", {wr_ena, tag_we, write_sel}, {1'b1, 1'b0, 8'h33});
        st_req = 1'b0;
        tick();
        check("idle_st_hold", {wr_ena, write_sel}, {1'b0, 8'h33});

        // T5: reset after beat 4 aborts the fill
        acks0 = ack_cnt;
        wrs0 = wr_cnt;
        mem_alt = 1'b0;
        mem_base = 32'h100;
        miss_addr = 32'h0000_1A40;
        miss_req = 1'b1;
        repeat (5) tick();
        check("t5_mid_fill", {busy, mem_req}, 2'b11);
        nRESET = 1'b0;
        miss_req = 1'b0;
        tick();
        check("t5_rst_state", {busy, mem_req, wr_ena, miss_ack}, 4'b0000);
        tick();
        nRESET = 1'b1;
        repeat (3) tick();
        check("t5_no_ack", ack_cnt - acks0, 0);
        check("t5_no_write", wr_cnt - wrs0, 0);
        do_fill(32'h0000_2000, 32'h200, 1'b0, 9, 1'b0, 8'h00, 8'h00, 19'h1);

        // T6: after the held-miss fills above, nothing restarts on its own
        acks0 = ack_cnt;
        repeat (4) tick();
        check("t6_quiet_busy", busy, 1'b0);
        check("t6_quiet_ack", ack_cnt - acks0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
